// File: rtl/xdma_finish_sender.sv
// xdma_finish_sender: turns each to-remote finish request into a single-beat
// AXI4 write of the DMA id to the previous hop's finish address, then tracks
// outstanding B responses and keeps a sticky error flag for non-OKAY replies.
//
// state | meaning
// ------+-----------------------------------------------------------
// Idle  | waiting for a finish request (accepted while count < max)
// Send  | AW and W of the captured request in flight, either order
module xdma_finish_sender #(
  parameter int unsigned AddrWidth      = 48,
  parameter int unsigned DataWidth      = 512,
  parameter int unsigned DmaIdWidth     = 8,
  parameter int unsigned AxiIdWidth     = 4,
  parameter int unsigned AxiId          = 0,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   finish_valid_i,
  output logic                   finish_ready_o,
  input  logic [AddrWidth-1:0]   remote_addr_i,
  input  logic [DmaIdWidth-1:0]  dma_id_i,
  output logic                   aw_valid_o,
  input  logic                   aw_ready_i,
  output logic [AddrWidth-1:0]   aw_addr_o,
  output logic [AxiIdWidth-1:0]  aw_id_o,
  output logic [7:0]             aw_len_o,
  output logic [2:0]             aw_size_o,
  output logic [1:0]             aw_burst_o,
  output logic                   w_valid_o,
  input  logic                   w_ready_i,
  output logic [DataWidth-1:0]   w_data_o,
  output logic [DataWidth/8-1:0] w_strb_o,
  output logic                   w_last_o,
  input  logic                   b_valid_i,
  output logic                   b_ready_o,
  input  logic [1:0]             b_resp_i,
  output logic                   busy_o,
  output logic                   err_o,
  input  logic                   err_clear_i
);

  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
  localparam int unsigned StrbW = DataWidth / 8;

  typedef enum logic {
    Idle = 1'b0,
    Send = 1'b1
  } state_e;

  state_e                  state_q;
  logic [AddrWidth-1:0]    addr_q;
  logic [DmaIdWidth-1:0]   id_q;
  logic                    aw_done_q;
  logic                    w_done_q;
  logic [CntW-1:0]         cnt_q;
  logic                    err_q;
  // Holds finish_ready_o low while in reset and for the first cycle after it.
  logic                    run_q;

  logic cnt_full;
  logic accept;
  logic aw_hs;
  logic w_hs;
  logic send_done;
  logic b_hs;

  assign cnt_full       = (cnt_q >= CntW'(MaxOutstanding));
  assign finish_ready_o = run_q && (state_q == Idle) && !cnt_full;
  assign accept         = finish_valid_i && finish_ready_o;

  assign aw_valid_o = (state_q == Send) && !aw_done_q;
  assign w_valid_o  = (state_q == Send) && !w_done_q;
  assign aw_hs      = aw_valid_o && aw_ready_i;
  assign w_hs       = w_valid_o && w_ready_i;
  // The request is complete in the cycle its last remaining channel handshakes.
  assign send_done  = (state_q == Send) && (aw_done_q || aw_hs) && (w_done_q || w_hs);

  assign b_ready_o = (cnt_q != '0);
  assign b_hs      = b_valid_i && b_ready_o;

  assign busy_o = (state_q != Idle) || (cnt_q != '0);
  assign err_o  = err_q;

  assign aw_addr_o  = addr_q;
  assign aw_id_o    = AxiIdWidth'(AxiId);
  assign aw_len_o   = 8'd0;
  assign aw_size_o  = 3'($clog2(StrbW));
  assign aw_burst_o = 2'b01;
  assign w_data_o   = DataWidth'(id_q);
  assign w_strb_o   = '1;
  assign w_last_o   = 1'b1;

  // Request FSM: capture on accept, track per-channel completion in Send.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= Idle;
      addr_q    <= '0;
      id_q      <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        Idle: begin
          if (accept) begin
            addr_q    <= remote_addr_i;
            id_q      <= dma_id_i;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            state_q   <= Send;
          end
        end
        Send: begin
          if (send_done) begin
            state_q <= Idle;
          end else begin
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
          end
        end
        default: state_q <= Idle;
      endcase
    end
  end

  // Outstanding write count: +1 on write completion, -1 on B handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      case ({send_done, b_hs})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Sticky error flag; a new error in the same cycle as a clear wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (b_hs && (b_resp_i != 2'b00)) begin
      err_q <= 1'b1;
    end else if (err_clear_i) begin
      err_q <= 1'b0;
    end
  end

  // Enable request acceptance once the block is out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

endmodule

// File: doc/xdma_finish_sender.md
Name: xdma_finish_sender

Overview:
- Downstream of the xDMA finish manager.
- Takes each to-remote finish request (remote address, DMA id) and turns it into a single-beat AXI4 write to the previous hop's finish address.
- The written data carries the DMA id.
- Tracks outstanding B responses and flags error responses. Upstream of the AXI crossbar master port.

Parameters:
- AddrWidth, 48, width of remote address and AXI awaddr
- DataWidth, 512, AXI data width; power of two, at least 64
- DmaIdWidth, 8, width of the DMA id carried in the finish word
- AxiIdWidth, 4, AXI transaction id width
- AxiId, 0, constant AXI id driven on aw_id_o
- MaxOutstanding, 4, maximum unacknowledged writes; at least 1

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- finish_valid_i  in  1  finish request valid
- finish_ready_o  out  1  finish request accepted
- remote_addr_i  in  AddrWidth  destination address of finish word
- dma_id_i  in  DmaIdWidth  DMA id to report
- aw_valid_o  out  1  AXI AW valid
- aw_ready_i  in  1  AXI AW ready
- aw_addr_o  out  AddrWidth  AXI write address
- aw_id_o  out  AxiIdWidth  constant AxiId
- aw_len_o  out  8  constant 0
- aw_size_o  out  3  constant log2(DataWidth/8)
- aw_burst_o  out  2  constant INCR (2'b01)
- w_valid_o  out  1  AXI W valid
- w_ready_i  in  1  AXI W ready
- w_data_o  out  DataWidth  finish word
- w_strb_o  out  DataWidth/8  all ones
- w_last_o  out  1  constant 1
- b_valid_i  in  1  AXI B valid
- b_ready_o  out  1  AXI B ready
- b_resp_i  in  2  AXI B response
- busy_o  out  1  request in flight or B responses pending
- err_o  out  1  sticky: a B response other than OKAY was seen
- err_clear_i  in  1  clears err_o

Behaviour:
- Reset: rst_ni is asynchronous active-low on clk_i. All valids low, finish_ready_o low, captured address/id zero, outstanding count zero, err_o low, busy_o low, FSM in Idle.
- FSM Idle:
  - finish_ready_o = (outstanding < MaxOutstanding), combinational; it is low in every other state.
  - On finish_valid_i && finish_ready_o: register remote_addr_i and dma_id_i, clear aw_done/w_done, go to Send next cycle.
  - Latency from accept to aw_valid_o/w_valid_o is 1 cycle.
- FSM Send:
  - aw_valid_o = !aw_done; w_valid_o = !w_done.
  - aw_addr_o = captured address. w_data_o = captured dma_id zero-extended to DataWidth.
  - AW and W handshakes are independent; either order, or both in the same cycle.
  - The cycle in which the last outstanding channel handshakes (both together, or the remaining one): increment the outstanding count and return to Idle.
  - A valid, once raised, holds with stable payload until its ready.
  - aw_*/w_* payload outputs are don't-care-stable: they hold the captured values in all states.
- B channel:
  - b_ready_o = (outstanding != 0).
  - A B handshake decrements the count.
  - Increment and decrement in the same cycle leave the count unchanged.
  - The count never exceeds MaxOutstanding and never underflows.
  - b_valid_i while the count is zero is not handshaken.
- Error flag:
  - A B handshake with b_resp_i != 2'b00 sets err_o next cycle.
  - err_clear_i clears it. If a set and a clear occur in the same cycle, set wins.
- busy_o = (state != Idle) || (outstanding != 0), combinational.
- Count width: $clog2(MaxOutstanding+1).
- Reset mid-operation: pending AW/W is abandoned, valids drop immediately, count is zeroed; no recovery of lost responses.

Test Plan:
- Single finish (addr 0x1000_0040, id 0x5A), aw_ready/w_ready held high -> accept on cycle 0; aw_valid/w_valid high on cycle 1 with aw_addr 0x1000_0040, w_data[7:0]=0x5A, upper bits 0, strb all ones; B OKAY on cycle 3 -> busy_o low on cycle 4, err_o stays 0.
- W ready 3 cycles before AW ready, and the reverse -> each valid drops after its own handshake; exactly one write counted; FSM returns to Idle only after both handshakes.
- 5 back-to-back finishes (ids 1..5) with b_valid held low, MaxOutstanding=4 -> 4 writes issued, finish_ready_o low for the 5th until the first B handshake; then the 5th is accepted.
- B handshake in the same cycle the 4th write completes -> count stays at 3; no overflow/underflow; finish_ready_o high the next cycle.
- B response SLVERR (2'b10) -> err_o=1 the next cycle and stays set; err_clear_i pulse -> 0; simultaneous SLVERR and clear -> err_o=1.
- Assert rst_ni low while in Send with 2 outstanding -> all valids/ready low immediately, busy_o=0, err_o=0; a new finish after reset is processed normally.
